// File: rtl/mem_access_unit_if.sv
// Data-memory bus: word address, lane-shifted write data, byte enables,
// request strobes, returned read word and memory busywait.
interface mem_access_unit_if;
  logic [31:0] MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [3:0]  MEM_BYTE_EN;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  modport master (
    output MEM_ADDRESS, MEM_WRITEDATA, MEM_BYTE_EN,
    output MEM_READ, MEM_WRITE,
    input  MEM_READDATA, MEM_BUSYWAIT
  );

  modport slave (
    input  MEM_ADDRESS, MEM_WRITEDATA, MEM_BYTE_EN,
    input  MEM_READ, MEM_WRITE,
    output MEM_READDATA, MEM_BUSYWAIT
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access controller: request/busywait handshake, lane alignment,
// byte enables, load extension, pipeline stall, misalign/timeout/illegal flags.
// Ports: CLK, RESET (sync, active-low), DATAMEMSEL, READ_WRITE, ALU_RESULT,
// DATA2 in; LOAD_DATA, BUSYWAIT, MISALIGNED, MEM_ERROR out; mem = memory bus.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        DATAMEMSEL,
  input  logic [3:0]  READ_WRITE,
  input  logic [31:0] ALU_RESULT,
  input  logic [31:0] DATA2,
  output logic [31:0] LOAD_DATA,
  output logic        BUSYWAIT,
  output logic        MISALIGNED,
  output logic        MEM_ERROR,
  mem_access_unit_if.master mem
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [3:0]      op;
  logic [1:0]      lane;

  logic [2:0]      f3;
  logic            is_st;
  logic            legal;
  logic            mis_in;
  logic [3:0]      be_in;
  logic [31:0]     wd_in;
  logic            go_acc, go_mis, go_ill;
  logic            fin_ok, fin_to;
  logic [31:0]     rsh;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;
  logic [31:0]     ld;

  assign f3    = READ_WRITE[2:0];
  assign is_st = READ_WRITE[3];

  // funct3[2] marks the unsigned loads; stores have no such variants
  assign legal  = (f3[1:0] != 2'b11) &&
                  (!f3[2] || (!is_st && !f3[1]));
  assign mis_in = ((f3[1:0] == 2'b01) && ALU_RESULT[0]) ||
                  ((f3[1:0] == 2'b10) && |ALU_RESULT[1:0]);

  always_comb begin
    be_in = 4'b0000;
    wd_in = DATA2;
    case (f3[1:0])
      2'b00: begin
        be_in = 4'b0001 << ALU_RESULT[1:0];
        wd_in = {4{DATA2[7:0]}};
      end
      2'b01: begin
        be_in = ALU_RESULT[1] ? 4'b1100 : 4'b0011;
        wd_in = {2{DATA2[15:0]}};
      end
      2'b10: be_in = 4'b1111;
      default: be_in = 4'b0000;
    endcase
  end

  always_comb begin
    state_n = state;
    go_acc  = 1'b0;
    go_mis  = 1'b0;
    go_ill  = 1'b0;
    fin_ok  = 1'b0;
    fin_to  = 1'b0;
    unique case (state)
      IDLE: begin
        if (DATAMEMSEL) begin
          unique case (1'b1)
            !legal: begin
              go_ill  = 1'b1;
              state_n = DONE;
            end
            legal && mis_in: begin
              go_mis  = 1'b1;
              state_n = DONE;
            end
            legal && !mis_in: begin
              go_acc  = 1'b1;
              state_n = ACCESS;
            end
          endcase
        end
      end
      ACCESS: begin
        if (!mem.MEM_BUSYWAIT) begin
          fin_ok  = 1'b1;
          state_n = DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          fin_to  = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign BUSYWAIT = RESET &
                    (((state == IDLE) && DATAMEMSEL) ||
                     (state == ACCESS));

  // lane select from the latched address, not the live one
  assign rsh   = mem.MEM_READDATA >> {lane, 3'b000};
  assign rbyte = rsh[7:0];
  assign rhalf = lane[1] ? mem.MEM_READDATA[31:16]
                         : mem.MEM_READDATA[15:0];

  always_comb begin
    ld = 32'd0;
    case (op[1:0])
      2'b00:   ld = {{24{rbyte[7] & ~op[2]}}, rbyte};
      2'b01:   ld = {{16{rhalf[15] & ~op[2]}}, rhalf};
      2'b10:   ld = mem.MEM_READDATA;
      default: ld = 32'd0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt               <= '0;
      op                <= 4'd0;
      lane              <= 2'd0;
      mem.MEM_ADDRESS   <= 32'd0;
      mem.MEM_WRITEDATA <= 32'd0;
      mem.MEM_BYTE_EN   <= 4'd0;
      mem.MEM_READ      <= 1'b0;
      mem.MEM_WRITE     <= 1'b0;
      LOAD_DATA         <= 32'd0;
      MISALIGNED        <= 1'b0;
      MEM_ERROR         <= 1'b0;
    end else begin
      if (go_acc || go_mis || go_ill) begin
        cnt               <= '0;
        op                <= READ_WRITE;
        lane              <= ALU_RESULT[1:0];
        mem.MEM_ADDRESS   <= {ALU_RESULT[31:2], 2'b00};
        mem.MEM_WRITEDATA <= wd_in;
        mem.MEM_BYTE_EN   <= be_in;
        mem.MEM_READ      <= go_acc && !is_st;
        mem.MEM_WRITE     <= go_acc && is_st;
        LOAD_DATA         <= 32'd0;
        MISALIGNED        <= go_mis;
        MEM_ERROR         <= go_ill;
      end
      if (state == ACCESS && mem.MEM_BUSYWAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (fin_ok) begin
        mem.MEM_READ  <= 1'b0;
        mem.MEM_WRITE <= 1'b0;
        if (!op[3]) LOAD_DATA <= ld;
      end
      if (fin_to) begin
        mem.MEM_READ  <= 1'b0;
        mem.MEM_WRITE <= 1'b0;
        LOAD_DATA     <= 32'd0;
        MEM_ERROR     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and random accesses against a
// transaction-level model of the expected bus activity and results.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        DATAMEMSEL = 1'b0;
  logic [3:0]  READ_WRITE = 4'd0;
  logic [31:0] ALU_RESULT = 32'd0;
  logic [31:0] DATA2 = 32'd0;
  logic [31:0] LOAD_DATA;
  logic        BUSYWAIT;
  logic        MISALIGNED;
  logic        MEM_ERROR;

  mem_access_unit_if bus();

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .DATAMEMSEL(DATAMEMSEL),
    .READ_WRITE(READ_WRITE),
    .ALU_RESULT(ALU_RESULT),
    .DATA2(DATA2),
    .LOAD_DATA(LOAD_DATA),
    .BUSYWAIT(BUSYWAIT),
    .MISALIGNED(MISALIGNED),
    .MEM_ERROR(MEM_ERROR),
    .mem(bus)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int bw; int rd; int wr;
    logic [31:0] addr; logic [31:0] wd; logic [3:0] be;
    logic mis; logic err; logic ok; logic st;
    logic [31:0] ld;
  } exp_t;

  function automatic exp_t model(logic [3:0] op, logic [31:0] a,
                                 logic [31:0] d2, logic [31:0] rw, int nb);
    exp_t e;
    int lane, sz, acc;
    logic legal;
    logic [31:0] b, h;
    lane = int'(a[1:0]);
    sz   = int'(op[1:0]);
    e.st = op[3];
    legal = (op[2:0] <= 3'd2) ||
            (!op[3] && (op[2:0] == 3'd4 || op[2:0] == 3'd5));
    e.mis = legal && ((sz == 1 && lane % 2 == 1) || (sz == 2 && lane != 0));
    e.ok  = legal && !e.mis;
    acc   = (nb >= TO) ? TO : nb + 1;
    e.bw  = e.ok ? 1 + acc : 1;
    e.rd  = (e.ok && !e.st) ? acc : 0;
    e.wr  = (e.ok && e.st) ? acc : 0;
    e.err = !legal || (e.ok && nb >= TO);
    e.addr = a - 32'(lane);
    e.be = (sz == 0) ? 4'(1 << lane) :
           (sz == 1) ? ((lane >= 2) ? 4'hC : 4'h3) : 4'hF;
    e.wd = (sz == 0) ? {4{d2[7:0]}} :
           (sz == 1) ? {2{d2[15:0]}} : d2;
    e.ld = 32'd0;
    if (e.ok && !e.st && nb < TO) begin
      if (sz == 0) begin
        b = (rw >> (8 * lane)) & 32'hFF;
        e.ld = (!op[2] && b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      end else if (sz == 1) begin
        h = (rw >> ((lane >= 2) ? 16 : 0)) & 32'hFFFF;
        e.ld = (!op[2] && h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      end else begin
        e.ld = rw;
      end
    end
    return e;
  endfunction

  // Starts at IDLE, 1 time unit after a rising edge; returns likewise.
  task automatic exec(string nm, logic [3:0] op, logic [31:0] a,
                      logic [31:0] d2, logic [31:0] rw, int nb);
    exp_t e;
    int bw, rd, wr, i;
    logic [31:0] oaddr, owd, old;
    logic [3:0] obe;
    logic omis, oerr, stable, hold, tmo;
    e = model(op, a, d2, rw, nb);
    bw = 0; rd = 0; wr = 0; stable = 1'b1;
    oaddr = 32'd0; owd = 32'd0; obe = 4'd0;
    DATAMEMSEL = 1'b1;
    READ_WRITE = op;
    ALU_RESULT = a;
    DATA2 = d2;
    bus.MEM_BUSYWAIT = 1'($urandom);
    bus.MEM_READDATA = $urandom;
    #1;
    if (BUSYWAIT) bw++;
    rd += int'(bus.MEM_READ);
    wr += int'(bus.MEM_WRITE);
    @(posedge CLK); #1;
    DATAMEMSEL = 1'b0;
    READ_WRITE = 4'($urandom);
    ALU_RESULT = $urandom;
    DATA2 = $urandom;
    i = 0;
    while (BUSYWAIT && i < 300) begin
      rd += int'(bus.MEM_READ);
      wr += int'(bus.MEM_WRITE);
      if (i == 0) begin
        oaddr = bus.MEM_ADDRESS; owd = bus.MEM_WRITEDATA; obe = bus.MEM_BYTE_EN;
      end else if (oaddr !== bus.MEM_ADDRESS || owd !== bus.MEM_WRITEDATA ||
                   obe !== bus.MEM_BYTE_EN) begin
        stable = 1'b0;
      end
      if (i < nb) begin
        bus.MEM_BUSYWAIT = 1'b1;
        bus.MEM_READDATA = $urandom;
      end else begin
        bus.MEM_BUSYWAIT = 1'b0;
        bus.MEM_READDATA = rw;
      end
      bw++; i++;
      @(posedge CLK); #1;
    end
    tmo = (i >= 300);
    rd += int'(bus.MEM_READ);
    wr += int'(bus.MEM_WRITE);
    if (i == 0) begin
      oaddr = bus.MEM_ADDRESS; owd = bus.MEM_WRITEDATA; obe = bus.MEM_BYTE_EN;
    end
    omis = MISALIGNED; oerr = MEM_ERROR; old = LOAD_DATA;
    bus.MEM_BUSYWAIT = 1'($urandom);
    bus.MEM_READDATA = $urandom;
    @(posedge CLK); #1;
    hold = (MISALIGNED === omis) && (MEM_ERROR === oerr) &&
           (LOAD_DATA === old) && !bus.MEM_READ && !bus.MEM_WRITE;

    n_chk++;
    if (tmo !== 1'b0) begin
      n_fail++; $display("FAIL %s stall_bound got stuck in ACCESS", nm);
    end
    n_chk++;
    if (bw !== e.bw) begin
      n_fail++; $display("FAIL %s busywait_cycles got %0d exp %0d", nm, bw, e.bw);
    end
    n_chk++;
    if (rd !== e.rd) begin
      n_fail++; $display("FAIL %s read_cycles got %0d exp %0d", nm, rd, e.rd);
    end
    n_chk++;
    if (wr !== e.wr) begin
      n_fail++; $display("FAIL %s write_cycles got %0d exp %0d", nm, wr, e.wr);
    end
    n_chk++;
    if (oaddr !== e.addr) begin
      n_fail++; $display("FAIL %s mem_address got %h exp %h", nm, oaddr, e.addr);
    end
    n_chk++;
    if (omis !== e.mis) begin
      n_fail++; $display("FAIL %s misaligned got %b exp %b", nm, omis, e.mis);
    end
    n_chk++;
    if (oerr !== e.err) begin
      n_fail++; $display("FAIL %s mem_error got %b exp %b", nm, oerr, e.err);
    end
    n_chk++;
    if (old !== e.ld) begin
      n_fail++; $display("FAIL %s load_data got %h exp %h", nm, old, e.ld);
    end
    n_chk++;
    if (stable !== 1'b1 || hold !== 1'b1) begin
      n_fail++;
      $display("FAIL %s hold got stable=%b hold=%b exp 1 1", nm, stable, hold);
    end
    if (e.ok) begin
      n_chk++;
      if (obe !== e.be) begin
        n_fail++; $display("FAIL %s byte_en got %b exp %b", nm, obe, e.be);
      end
      if (e.st) begin
        n_chk++;
        if (owd !== e.wd) begin
          n_fail++; $display("FAIL %s writedata got %h exp %h", nm, owd, e.wd);
        end
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    DATAMEMSEL = 1'b1;
    READ_WRITE = 4'b0010;
    ALU_RESULT = 32'h0000_0100;
    bus.MEM_BUSYWAIT = 1'b0;
    bus.MEM_READDATA = 32'hFFFF_FFFF;
    repeat (2) @(posedge CLK);
    #1;
    n_chk++;
    if (BUSYWAIT !== 1'b0) begin
      n_fail++; $display("FAIL reset busywait got %b exp 0", BUSYWAIT);
    end
    n_chk++;
    if ({bus.MEM_READ, bus.MEM_WRITE, bus.MEM_BYTE_EN} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset strobes got %b%b be %b exp 0",
               bus.MEM_READ, bus.MEM_WRITE, bus.MEM_BYTE_EN);
    end
    n_chk++;
    if (bus.MEM_ADDRESS !== 32'd0 || bus.MEM_WRITEDATA !== 32'd0) begin
      n_fail++;
      $display("FAIL reset bus got %h %h exp 0", bus.MEM_ADDRESS, bus.MEM_WRITEDATA);
    end
    n_chk++;
    if (LOAD_DATA !== 32'd0 || MISALIGNED !== 1'b0 || MEM_ERROR !== 1'b0) begin
      n_fail++;
      $display("FAIL reset flags got %h %b %b exp 0", LOAD_DATA, MISALIGNED, MEM_ERROR);
    end
    DATAMEMSEL = 1'b0;
    RESET = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_lw_busy();
    exec("lw_busy", 4'b0010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 2);
  endtask

  task automatic test_lb_lbu();
    exec("lb", 4'b0000, 32'h0000_0103, 32'h0, 32'h80FF_7F01, 0);
    exec("lbu", 4'b0100, 32'h0000_0103, 32'h0, 32'h80FF_7F01, 1);
    exec("lh_hi", 4'b0001, 32'h0000_0102, 32'h0, 32'h80FF_7F01, 0);
    exec("lhu_lo", 4'b0101, 32'h0000_0100, 32'h0, 32'h80FF_FF01, 0);
  endtask

  task automatic test_store();
    exec("sh", 4'b1001, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 1);
    exec("sb", 4'b1000, 32'h0000_0301, 32'h0000_00A5, 32'h0, 0);
    exec("sw", 4'b1010, 32'h0000_0404, 32'hCAFE_F00D, 32'h0, 3);
  endtask

  task automatic test_misaligned();
    exec("lw_mis", 4'b0010, 32'h0000_0101, 32'h0, 32'h0, 0);
    exec("sh_mis", 4'b1001, 32'h0000_0003, 32'h0, 32'h0, 0);
  endtask

  task automatic test_timeout();
    exec("lw_timeout", 4'b0010, 32'h0000_0500, 32'h0, 32'h1111_2222, 50);
    exec("sw_last_ok", 4'b1010, 32'h0000_0600, 32'h0BAD_CAFE, 32'h0, TO - 1);
  endtask

  task automatic test_illegal_idle_hold();
    exec("illegal", 4'b1100, 32'h0000_0700, 32'h0, 32'h0, 0);
    for (int k = 0; k < 4; k++) begin
      bus.MEM_BUSYWAIT = 1'($urandom);
      READ_WRITE = 4'($urandom);
      @(posedge CLK); #1;
      n_chk++;
      if (BUSYWAIT !== 1'b0 || MEM_ERROR !== 1'b1 || bus.MEM_READ !== 1'b0 ||
          bus.MEM_WRITE !== 1'b0 || bus.MEM_ADDRESS !== 32'h0000_0700) begin
        n_fail++;
        $display("FAIL idle_hold got bw=%b err=%b rd=%b wr=%b addr=%h exp 0 1 0 0 00000700",
                 BUSYWAIT, MEM_ERROR, bus.MEM_READ, bus.MEM_WRITE, bus.MEM_ADDRESS);
      end
    end
  endtask

  task automatic test_back_to_back();
    exec("b2b_lw", 4'b0010, 32'h0000_0010, 32'h0, 32'h0102_0304, 0);
    exec("b2b_sb", 4'b1000, 32'h0000_0012, 32'h0000_007E, 32'h0, 0);
    exec("b2b_lh", 4'b0001, 32'h0000_0016, 32'h0, 32'hF00F_0FF0, 2);
  endtask

  task automatic test_reset_mid();
    DATAMEMSEL = 1'b1;
    READ_WRITE = 4'b0010;
    ALU_RESULT = 32'h0000_0900;
    bus.MEM_BUSYWAIT = 1'b1;
    @(posedge CLK); #1;
    DATAMEMSEL = 1'b0;
    @(posedge CLK); #1;
    n_chk++;
    if (bus.MEM_READ !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid pre_read got %b exp 1", bus.MEM_READ);
    end
    RESET = 1'b0;
    #1;
    n_chk++;
    if (BUSYWAIT !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid busywait got %b exp 0", BUSYWAIT);
    end
    @(posedge CLK); #1;
    n_chk++;
    if (bus.MEM_READ !== 1'b0 || bus.MEM_WRITE !== 1'b0 || bus.MEM_ADDRESS !== 32'd0 ||
        bus.MEM_BYTE_EN !== 4'd0 || bus.MEM_WRITEDATA !== 32'd0 ||
        LOAD_DATA !== 32'd0 || MISALIGNED !== 1'b0 || MEM_ERROR !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid outputs got rd=%b wr=%b addr=%h be=%b ld=%h exp all 0",
               bus.MEM_READ, bus.MEM_WRITE, bus.MEM_ADDRESS, bus.MEM_BYTE_EN, LOAD_DATA);
    end
    RESET = 1'b1;
    bus.MEM_BUSYWAIT = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 80; k++) begin
      exec("random", 4'($urandom), $urandom, $urandom, $urandom,
           int'($urandom_range(0, 6)));
    end
  endtask

  initial begin
    bus.MEM_BUSYWAIT = 1'b0;
    bus.MEM_READDATA = 32'd0;
    test_reset();
    test_lw_busy();
    test_lb_lbu();
    test_store();
    test_misaligned();
    test_timeout();
    test_illegal_idle_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller sitting directly downstream of the EX/MEM pipeline register. It accepts the registered address, store data and access code, runs a request/busywait handshake with the data memory, and performs byte-lane alignment, byte enables and load sign/zero extension. It drives the pipeline-wide stall so that EX/MEM, and every register upstream of it, holds until the access resolves.

## Interface
- TIMEOUT, 255: maximum cycles MEM_BUSYWAIT may stay high before the access is aborted; counter width is $clog2(TIMEOUT+1).
- Reset: one clock; reset is synchronous and active-low.
- CLK  in  1  pipeline clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-low reset.
- DATAMEMSEL  in  1  the instruction held in EX/MEM is a memory access.
- READ_WRITE  in  4  bit3: 1 = store, 0 = load; bits 2:0 = RV32 funct3.
- ALU_RESULT  in  32  byte address.
- DATA2  in  32  store data, right-aligned.
- MEM_READDATA  in  32  word from memory.
- MEM_BUSYWAIT  in  1  memory is not ready.
- MEM_ADDRESS  out  32  word address: latched address with [1:0] forced to 00.
- MEM_WRITEDATA  out  32  lane-shifted store data.
- MEM_BYTE_EN  out  4  byte-lane enables.
- MEM_READ, MEM_WRITE  out  1 each  registered request strobes.
- LOAD_DATA  out  32  extended load result; valid in DONE.
- BUSYWAIT  out  1  combinational stall to all pipeline registers.
- MISALIGNED  out  1  high in DONE for a misaligned access.
- MEM_ERROR  out  1  high in DONE for a timeout or illegal code.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE with DATAMEMSEL=1:
  - Latch the address, lane-shifted data, byte enables and op.
  - Legal and aligned: go to ACCESS; assert MEM_READ or MEM_WRITE from the next edge.
  - Misaligned: go to DONE with MISALIGNED=1.
  - Illegal code: go to DONE with MEM_ERROR=1.
  - No memory request is issued in either error case.
- Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal store funct3: 000 SB, 001 SH, 010 SW. Every other code is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠00.
- Byte enables:
  - SB/LB/LBU: 0001 << addr[1:0]; store byte replicated into all lanes.
  - SH/LH/LHU: 0011 when addr[1]=0, 1100 when addr[1]=1; store half replicated into both halves.
  - Word: 1111.
- ACCESS:
  - Hold the request stable.
  - On an edge with MEM_BUSYWAIT=0: for a load, capture the selected lane of MEM_READDATA, sign-extended (LB/LH) or zero-extended (LBU/LHU). Then drop the strobes and go to DONE.
  - The counter increments on every ACCESS edge with MEM_BUSYWAIT=1. When it reaches TIMEOUT: drop the strobes, set LOAD_DATA=0 and MEM_ERROR=1, and go to DONE.
- DONE: always returns to IDLE on the next edge. Flags and LOAD_DATA hold until the next access leaves IDLE.
- LOAD_DATA is 0 for stores and for error terminations.
- BUSYWAIT = RESET & ((IDLE & DATAMEMSEL) | ACCESS). It is low in DONE, so EX/MEM advances at the end of DONE.

## Timing
- Reset (RESET=0 at an edge):
  - Next state IDLE; counter 0.
  - MEM_READ=0, MEM_WRITE=0, MEM_BYTE_EN=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
  - LOAD_DATA=0, MISALIGNED=0, MEM_ERROR=0.
  - BUSYWAIT is forced to 0 while RESET=0.
- Reset mid-ACCESS: strobes drop at that edge; no capture; no flags.
- Minimum legal access takes 3 cycles: IDLE detect, 1 ACCESS cycle, DONE.
- An access with k busy cycles spends 1+k cycles in ACCESS.
- Error access takes 2 cycles: IDLE, then DONE.
- Back-to-back accesses: the instruction arriving after DONE is detected in IDLE on the following cycle. There is no bubble beyond the DONE cycle.
- DATAMEMSEL=0 in IDLE: remain in IDLE, no stall, outputs hold.
- MEM_BUSYWAIT is ignored outside ACCESS.
- Inputs are sampled only at the IDLE→ACCESS/DONE edge. Later input changes have no effect.

## Test plan
- LW, addr 0x100, memory ready after 2 busy cycles, word 0xDEADBEEF:
  - MEM_READ high for 3 cycles; MEM_ADDRESS=0x100; MEM_BYTE_EN=1111.
  - LOAD_DATA=0xDEADBEEF in DONE.
  - BUSYWAIT high for 4 cycles.
- LB/LBU, addr 0x103, word 0x80FF7F01:
  - LB gives LOAD_DATA=0xFFFFFF80; LBU gives 0x00000080.
  - MEM_BYTE_EN=1000.
- SH, addr 0x202, DATA2=0x1234ABCD:
  - MEM_WRITE asserted; MEM_ADDRESS=0x200; MEM_BYTE_EN=1100.
  - MEM_WRITEDATA=0xABCDABCD; LOAD_DATA=0.
- LW at addr 0x101, then SH at 0x003:
  - Each gives MISALIGNED=1 in DONE.
  - MEM_READ/MEM_WRITE never assert; BUSYWAIT high for 1 cycle.
- TIMEOUT=4, MEM_BUSYWAIT stuck at 1:
  - Strobe drops after 4 ACCESS cycles.
  - MEM_ERROR=1, LOAD_DATA=0, state returns to IDLE.
- Illegal code READ_WRITE=1100: MEM_ERROR=1 with no request. Separately, RESET=0 in the second ACCESS cycle: strobes and BUSYWAIT are 0 after that edge, and all outputs are at reset values.
